// File: rtl/cmd_frame_master.sv
// Host-side UART command initiator: serialises a command into a byte frame and assembles the reply.
// Optional macro CFM_CMD_QUEUE_EN adds a one-entry command holding register for back-to-back commands.
module cmd_frame_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [3:0]              cmd_func,
  output logic [DATA_WIDTH-1:0]   tx_byte,
  output logic                    tx_byte_valid,
  input  logic                    tx_byte_ready,
  input  logic [DATA_WIDTH-1:0]   rx_byte,
  input  logic                    rx_byte_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_valid,
  output logic                    rsp_timeout,
  output logic                    busy
);
  // state    | meaning
  // S_IDLE   | no command in flight
  // S_SEND   | offering frame byte idx to UART TX
  // S_WAIT   | collecting response bytes, timeout timer running
  // S_DONE   | one-cycle response strobe
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] T_RF_WR   = 2'd0;
  localparam logic [1:0] T_RF_RD   = 2'd1;
  localparam logic [1:0] T_ALU_OP  = 2'd2;
  localparam logic [1:0] T_ALU_NOP = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [1:0]            idx;
  logic [TW-1:0]         timer;
  logic                  rx_cnt;
  logic [DATA_WIDTH-1:0] rsp_lo;
  logic [1:0]            c_type;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [DATA_WIDTH-1:0] c_op_b;
  logic [3:0]            c_func;

  logic [DATA_WIDTH-1:0] frame_byte;
  logic [1:0]            frame_last;
  logic                  rx_last;
  logic                  tx_xfer;
  logic                  exit_op;
  logic                  launch_in;
  logic                  launch_hold;

  always_comb begin
    frame_byte = '0;
    frame_last = 2'd0;
    case (c_type)
      T_RF_WR: begin
        frame_last = 2'd2;
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hAA);
          2'd1:    frame_byte = DATA_WIDTH'(c_addr);
          default: frame_byte = c_data;
        endcase
      end
      T_RF_RD: begin
        frame_last = 2'd1;
        frame_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(c_addr);
      end
      T_ALU_OP: begin
        frame_last = 2'd3;
        case (idx)
          2'd0:    frame_byte = DATA_WIDTH'(8'hCC);
          2'd1:    frame_byte = c_data;
          2'd2:    frame_byte = c_op_b;
          default: frame_byte = DATA_WIDTH'(c_func);
        endcase
      end
      default: begin
        frame_last = 2'd1;
        frame_byte = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(c_func);
      end
    endcase
  end

  assign tx_byte       = (state == S_SEND) ? frame_byte : '0;
  assign tx_byte_valid = (state == S_SEND);
  assign rsp_valid     = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign tx_xfer       = (state == S_SEND) && tx_byte_ready;
  assign rx_last       = (c_type == T_RF_RD) || rx_cnt;
  assign exit_op       = (state == S_DONE) ||
                         ((state == S_WAIT) && !rx_byte_valid && (timer == '0));

`ifdef CFM_CMD_QUEUE_EN
  logic                  hold_full;
  logic [1:0]            h_type;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_data;
  logic [DATA_WIDTH-1:0] h_op_b;
  logic [3:0]            h_func;
  logic                  hold_load;

  assign cmd_ready   = !hold_full;
  assign launch_hold = hold_full && ((state == S_IDLE) || exit_op);
  assign hold_load   = cmd_valid && !hold_full && (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      h_type    <= '0;
      h_addr    <= '0;
      h_data    <= '0;
      h_op_b    <= '0;
      h_func    <= '0;
    end else if (hold_load) begin
      hold_full <= 1'b1;
      h_type    <= cmd_type;
      h_addr    <= cmd_addr;
      h_data    <= cmd_data;
      h_op_b    <= cmd_op_b;
      h_func    <= cmd_func;
    end else if (launch_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign cmd_ready   = (state == S_IDLE);
  assign launch_hold = 1'b0;
`endif

  assign launch_in = cmd_valid && cmd_ready && (state == S_IDLE);

  // Timer loads TIMEOUT_CYCLES-1 and counts down; zero is the last cycle a byte can still arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      timer       <= '0;
      rx_cnt      <= 1'b0;
      rsp_lo      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      c_type      <= '0;
      c_addr      <= '0;
      c_data      <= '0;
      c_op_b      <= '0;
      c_func      <= '0;
    end else begin
      rsp_timeout <= 1'b0;
      case (state)
        S_SEND: begin
          if (tx_xfer) begin
            if (idx == frame_last) begin
              if (c_type == T_RF_WR) begin
                rsp_data <= '0;
                state    <= S_DONE;
              end else begin
                timer  <= T_LOAD;
                rx_cnt <= 1'b0;
                state  <= S_WAIT;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        S_WAIT: begin
          if (rx_byte_valid) begin
            timer <= T_LOAD;
            if (rx_last) begin
              rsp_data <= rx_cnt ? {rx_byte, rsp_lo} : {{DATA_WIDTH{1'b0}}, rx_byte};
              state    <= S_DONE;
            end else begin
              rsp_lo <= rx_byte;
              rx_cnt <= 1'b1;
            end
          end else if (timer == '0) begin
            rsp_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase
      if (launch_in) begin
        c_type <= cmd_type;
        c_addr <= cmd_addr;
        c_data <= cmd_data;
        c_op_b <= cmd_op_b;
        c_func <= cmd_func;
      end
`ifdef CFM_CMD_QUEUE_EN
      else if (launch_hold) begin
        c_type <= h_type;
        c_addr <= h_addr;
        c_data <= h_data;
        c_op_b <= h_op_b;
        c_func <= h_func;
      end
`endif
      if (launch_in || launch_hold) begin
        state <= S_SEND;
        idx   <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed bench for cmd_frame_master with a 16-cycle response timeout.
// The holding-register scenario is exercised only when CFM_CMD_QUEUE_EN is defined.
module tb_cmd_frame_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic [7:0]  cmd_op_b = '0;
  logic [3:0]  cmd_func = '0;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic        tx_byte_ready = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_byte_valid = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq [4];
  int cyc;
  int cnt;
  logic saw_valid;

  cmd_frame_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_op_b(cmd_op_b), .cmd_func(cmd_func),
    .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] b, input logic [3:0] f);
    cmd_type = t; cmd_addr = a; cmd_data = d; cmd_op_b = b; cmd_func = f;
    cmd_valid = 1'b1;
    chk("cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = ~t; cmd_addr = ~a; cmd_data = 8'hFF; cmd_op_b = 8'hEE; cmd_func = ~f;
  endtask

  task automatic collect_tx(input int n, input logic [3:0] pat, output int cycles);
    int got = 0;
    int k = 0;
    logic pend = 1'b0;
    logic [7:0] held = '0;
    cycles = 0;
    while (got < n && cycles < 40) begin
      tx_byte_ready = pat[k % 4];
      k++;
      if (pend) begin
        chk("tx_hold_valid", 32'(tx_byte_valid), 1);
        chk("tx_hold_byte", 32'(tx_byte), 32'(held));
      end
      pend = 1'b0;
      if (tx_byte_valid) begin
        if (tx_byte_ready) begin
          txq[got] = tx_byte;
          got++;
        end else begin
          pend = 1'b1;
          held = tx_byte;
        end
      end
      cycles++;
      @(negedge clk);
    end
    if (got < n) chk("tx_budget", 32'(got), 32'(n));
  endtask

  task automatic rx_one(input logic [7:0] b);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    @(negedge clk);
    rx_byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_tx_valid", 32'(tx_byte_valid), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: RF_WR, READY held high
    chk("t1_pre_valid", 32'(tx_byte_valid), 0);
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    chk("t1_valid_rise", 32'(tx_byte_valid), 1);
    collect_tx(3, 4'hF, cyc);
    chk("t1_b0", 32'(txq[0]), 'hAA);
    chk("t1_b1", 32'(txq[1]), 'h05);
    chk("t1_b2", 32'(txq[2]), 'h3C);
    chk("t1_no_bubble", 32'(cyc), 3);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_data", 32'(rsp_data), 'h0000);
    @(negedge clk);
    chk("t1_rsp_pulse", 32'(rsp_valid), 0);
    chk("t1_busy", 32'(busy), 0);

    // 2: RF_RD, response after ~10 cycles
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    collect_tx(2, 4'hF, cyc);
    chk("t2_b0", 32'(txq[0]), 'hBB);
    chk("t2_b1", 32'(txq[1]), 'h02);
    saw_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (rsp_valid || rsp_timeout || !busy) saw_valid = 1'b1;
      @(negedge clk);
    end
    chk("t2_waiting", 32'(saw_valid), 0);
    rx_one(8'h81);
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_data", 32'(rsp_data), 'h0081);
    @(negedge clk);
    rx_one(8'hEE);
    chk("t2_stray_rx", 32'(rsp_data), 'h0081);
    chk("t2_stray_busy", 32'(busy), 0);

    // 3: ALU_OP with READY toggling
    issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h0);
    collect_tx(4, 4'b0110, cyc);
    chk("t3_b0", 32'(txq[0]), 'hCC);
    chk("t3_b1", 32'(txq[1]), 'h12);
    chk("t3_b2", 32'(txq[2]), 'h34);
    chk("t3_b3", 32'(txq[3]), 'h00);
    tx_byte_ready = 1'b1;
    rx_one(8'h46);
    chk("t3_mid_valid", 32'(rsp_valid), 0);
    chk("t3_mid_data", 32'(rsp_data), 'h0081);
    rx_one(8'h00);
    chk("t3_rsp_valid", 32'(rsp_valid), 1);
    chk("t3_rsp_data", 32'(rsp_data), 'h0046);
    @(negedge clk);

    // 4: ALU_NOP, no response -> timeout 16 cycles after last transfer
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h2);
    collect_tx(2, 4'hF, cyc);
    chk("t4_b0", 32'(txq[0]), 'hDD);
    chk("t4_b1", 32'(txq[1]), 'h02);
    cnt = 0;
    saw_valid = 1'b0;
    while (!rsp_timeout && cnt < 40) begin
      if (rsp_valid) saw_valid = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk("t4_timeout_lat", 32'(cnt), 16);
    chk("t4_no_rsp_valid", 32'(saw_valid | rsp_valid), 0);
    chk("t4_cmd_ready", 32'(cmd_ready), 1);
    chk("t4_rsp_data_kept", 32'(rsp_data), 'h0046);
    @(negedge clk);
    chk("t4_timeout_pulse", 32'(rsp_timeout), 0);

    // byte arriving in the terminal-count cycle wins over the timeout
    issue(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
    collect_tx(2, 4'hF, cyc);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("tc_still_wait", 32'(busy), 1);
    rx_one(8'h3E);
    chk("tc_rsp_valid", 32'(rsp_valid), 1);
    chk("tc_no_timeout", 32'(rsp_timeout), 0);
    chk("tc_rsp_data", 32'(rsp_data), 'h003E);
    @(negedge clk);
    chk("tc_no_late_timeout", 32'(rsp_timeout), 0);

    // 5: reset in the middle of a frame
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    chk("t5_b0", 32'(tx_byte), 'hAA);
    @(negedge clk);
    chk("t5_b1_offered", 32'(tx_byte), 'h05);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(tx_byte_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_rsp_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
    collect_tx(2, 4'hF, cyc);
    chk("t5_rd_b0", 32'(txq[0]), 'hBB);
    chk("t5_rd_b1", 32'(txq[1]), 'h07);

    // 6: second command while waiting for a response
    @(negedge clk);
`ifdef CFM_CMD_QUEUE_EN
    issue(2'd0, 4'h9, 8'h5A, 8'h00, 4'h0);
    chk("t6_hold_full", 32'(cmd_ready), 0);
    chk("t6_busy", 32'(busy), 1);
    rx_one(8'h5A);
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_data", 32'(rsp_data), 'h005A);
    @(negedge clk);
    chk("t6_back_to_back", 32'(tx_byte_valid), 1);
    chk("t6_first_byte", 32'(tx_byte), 'hAA);
    chk("t6_busy_kept", 32'(busy), 1);
    collect_tx(3, 4'hF, cyc);
    chk("t6_b1", 32'(txq[1]), 'h09);
    chk("t6_b2", 32'(txq[2]), 'h5A);
    chk("t6_wr_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_wr_rsp_data", 32'(rsp_data), 0);
`else
    cmd_valid = 1'b1;
    chk("t6_ready_busy", 32'(cmd_ready), 0);
    chk("t6_busy", 32'(busy), 1);
    cmd_valid = 1'b0;
    rx_one(8'h5A);
    chk("t6_rsp_valid", 32'(rsp_valid), 1);
    chk("t6_rsp_data", 32'(rsp_data), 'h005A);
`endif
    @(negedge clk);
    chk("end_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
